// File: rtl/task_frame_mavg_if.sv
// Sample stream bundle for task_frame_mavg.
// master drives samples in, slave is the averaging block.
interface task_frame_mavg_if #(
    parameter int IW = 16,
    parameter int OW = 16
);
    logic                 i_valid;
    logic                 i_first;
    logic                 i_last;
    logic signed [IW-1:0] i_data;
    logic                 o_valid;
    logic                 o_last;
    logic signed [OW-1:0] o_data;
    logic                 o_frame_err;

    modport master (
        output i_valid, i_first, i_last, i_data,
        input  o_valid, o_last, o_data, o_frame_err
    );

    modport slave (
        input  i_valid, i_first, i_last, i_data,
        output o_valid, o_last, o_data, o_frame_err
    );
endinterface

// File: rtl/task_frame_mavg.sv
// Per-frame moving average over 2^LOG2_WINDOW samples, saturated output.
// Optional macro TASK_MAVG_ROUND_EN: round half up instead of floor.
module task_frame_mavg #(
    parameter int TASK_INPUT_WIDTH  = 16,
    parameter int TASK_OUTPUT_WIDTH = 16,
    parameter int LOG2_WINDOW       = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    task_frame_mavg_if.slave bus
);
    localparam int IW = TASK_INPUT_WIDTH;
    localparam int OW = TASK_OUTPUT_WIDTH;
    localparam int W  = 1 << LOG2_WINDOW;
    localparam int AW = IW + LOG2_WINDOW;
    localparam int PW = (LOG2_WINDOW > 0) ? LOG2_WINDOW : 1;
    localparam int CW = LOG2_WINDOW + 1;
    localparam int MW = ((AW > OW) ? AW : OW) + 1;

    localparam logic signed [MW-1:0] MAXV =
        {{(MW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [MW-1:0] MINV = ~MAXV;

    typedef enum logic {IDLE, IN_FRAME} state_e;

    state_e               state_q, state_d;
    logic                 accept, err_d, err_q;
    logic signed [IW-1:0] hist_q [W];
    logic        [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] xs, oldest;
    logic                 s1_valid_q, s1_last_q;
    logic signed [AW-1:0] sum_r, mean;
    logic signed [MW-1:0] mean_ext;
    logic signed [OW-1:0] sat_d;
    logic                 s2_valid_q, s2_last_q;
    logic signed [OW-1:0] s2_data_q;
    logic                 o_valid_q, o_last_q;
    logic signed [OW-1:0] o_data_q;

    // Frame state register
    always_ff @(posedge i_clk) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Frame open/close transitions; a first always (re)opens
    always_comb begin
        state_d = state_q;
        if (bus.i_valid) begin
            if (bus.i_first)
                state_d = bus.i_last ? IDLE : IN_FRAME;
            else if (state_q == IN_FRAME && bus.i_last)
                state_d = IDLE;
        end
    end

    // Accept decision and framing violation flags
    always_comb begin
        accept = bus.i_valid && (bus.i_first || state_q == IN_FRAME);
        err_d  = bus.i_valid &&
                 ((state_q == IDLE && !bus.i_first) ||
                  (state_q == IN_FRAME && bus.i_first));
    end

    // Window update; entries older than the frame start are masked by cnt
    always_comb begin
        xs       = AW'(signed'(bus.i_data));
        oldest   = (cnt_q == CW'(W)) ? AW'(hist_q[wr_ptr_q]) : '0;
        wr_ptr_d = (wr_ptr_q == PW'(W - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (bus.i_first) begin
            acc_d = xs;
            cnt_d = CW'(1);
        end else begin
            acc_d = acc_q + xs - oldest;
            cnt_d = (cnt_q == CW'(W)) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Stage 1: history, accumulator, error pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int i = 0; i < W; i++) hist_q[i] <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            s1_last_q  <= accept && bus.i_last;
            err_q      <= err_d;
            if (accept) begin
                hist_q[wr_ptr_q] <= bus.i_data;
                wr_ptr_q         <= wr_ptr_d;
                cnt_q            <= cnt_d;
                acc_q            <= acc_d;
            end
        end
    end

    // Divide by W (optionally rounded) and clamp to output range
    always_comb begin
`ifdef TASK_MAVG_ROUND_EN
        sum_r = acc_q + AW'(W / 2);
`else
        sum_r = acc_q;
`endif
        mean     = sum_r >>> LOG2_WINDOW;
        mean_ext = MW'(mean);
        if (mean_ext > MAXV)      mean_ext = MAXV;
        else if (mean_ext < MINV) mean_ext = MINV;
        sat_d = mean_ext[OW-1:0];
    end

    // Stage 2 and output alignment register
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_data_q  <= '0;
            o_valid_q  <= 1'b0;
            o_last_q   <= 1'b0;
            o_data_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_last_q  <= s1_last_q;
            if (s1_valid_q) s2_data_q <= sat_d;
            o_valid_q <= s2_valid_q;
            o_last_q  <= s2_last_q;
            if (s2_valid_q) o_data_q <= s2_data_q;
        end
    end

    assign bus.o_valid     = o_valid_q;
    assign bus.o_last      = o_last_q;
    assign bus.o_data      = o_data_q;
    assign bus.o_frame_err = err_q;
endmodule

// File: tb/tb_task_frame_mavg.sv
// Directed bench for task_frame_mavg with a windowed-sum scoreboard.
// Checks data, framing, latency, saturation, errors and reset.
module tb_task_frame_mavg;
    localparam int IW = 16;
    localparam int OW = 8;
    localparam int L  = 2;
    localparam int W  = 1 << L;

    typedef struct {
        int data;
        bit last;
        int due;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_err = 0;

    exp_t   q[$];
    int     eq[$];
    longint win[$];
    bit     m_in = 1'b0;

    task_frame_mavg_if #(.IW(IW), .OW(OW)) bus ();

    task_frame_mavg #(
        .TASK_INPUT_WIDTH (IW),
        .TASK_OUTPUT_WIDTH(OW),
        .LOG2_WINDOW      (L)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        int   d;
        if (bus.o_valid === 1'b1) begin
            n_chk++;
            assert (q.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_out got data=%0d cyc=%0d want none",
                       $signed(bus.o_data), cyc);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                d = int'($signed(bus.o_data));
                n_chk++;
                assert (d === e.data) else begin
                    n_err++;
                    $error("FAIL data got %0d want %0d", d, e.data);
                end
                n_chk++;
                assert (bus.o_last === e.last) else begin
                    n_err++;
                    $error("FAIL last got %0b want %0b", bus.o_last, e.last);
                end
                n_chk++;
                assert (cyc === e.due) else begin
                    n_err++;
                    $error("FAIL latency got cyc %0d want %0d", cyc, e.due);
                end
            end
        end
        if (bus.o_frame_err === 1'b1) begin
            n_chk++;
            assert (eq.size() != 0) else begin
                n_err++;
                $error("FAIL unexpected_err got pulse cyc=%0d want none", cyc);
            end
            if (eq.size() != 0) begin
                d = eq.pop_front();
                n_chk++;
                assert (cyc === d) else begin
                    n_err++;
                    $error("FAIL err_time got cyc %0d want %0d", cyc, d);
                end
            end
        end
    end

    function automatic int model_out();
        longint s = 0;
        longint m;
        foreach (win[i]) s += win[i];
`ifdef TASK_MAVG_ROUND_EN
        s += W / 2;
`endif
        m = s >>> L;
        if (m > 127)  m = 127;
        if (m < -128) m = -128;
        return int'(m);
    endfunction

    task automatic send(input int x, input bit f, input bit l);
        bit acc = 1'b0;
        bus.i_valid = 1'b1;
        bus.i_first = f;
        bus.i_last  = l;
        bus.i_data  = IW'(x);
        if (f) begin
            if (m_in) eq.push_back(cyc + 1);
            win.delete();
            win.push_back(longint'(x));
            m_in = !l;
            acc  = 1'b1;
        end else if (!m_in) begin
            eq.push_back(cyc + 1);
        end else begin
            win.push_back(longint'(x));
            if (win.size() > W) void'(win.pop_front());
            if (l) m_in = 1'b0;
            acc = 1'b1;
        end
        if (acc) q.push_back('{data: model_out(), last: l, due: cyc + 3});
        @(negedge clk);
        bus.i_valid = 1'b0;
        bus.i_first = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        idle(5);
        n_chk++;
        assert (q.size() == 0) else begin
            n_err++;
            $error("FAIL %s_pending got %0d outputs left want 0", tag, q.size());
        end
        n_chk++;
        assert (eq.size() == 0) else begin
            n_err++;
            $error("FAIL %s_err_pending got %0d errs left want 0", tag, eq.size());
        end
        q.delete();
        eq.delete();
    endtask

    task automatic chk_reset(input string tag);
        n_chk++;
        assert (bus.o_valid === 1'b0 && bus.o_last === 1'b0 &&
                bus.o_data === '0 && bus.o_frame_err === 1'b0) else begin
            n_err++;
            $error("FAIL %s got v=%0b l=%0b d=%0d e=%0b want all 0", tag,
                   bus.o_valid, bus.o_last, $signed(bus.o_data),
                   bus.o_frame_err);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_valid = 1'b0;
        bus.i_first = 1'b0;
        bus.i_last  = 1'b0;
        bus.i_data  = '0;
        idle(3);
        chk_reset("reset_state");
        rst_n = 1'b1;
        idle(2);

        send(4, 1, 0);
        send(8, 0, 0);
        send(12, 0, 0);
        send(16, 0, 0);
        send(20, 0, 1);
        drain("ramp");

        send(-1, 1, 1);
        drain("single");

        for (int i = 0; i < 4; i++) send(1000, i == 0, i == 3);
        for (int i = 0; i < 4; i++) send(-1000, i == 0, i == 3);
        drain("sat");

        send(4, 1, 0);
        send(4, 0, 0);
        send(8, 1, 0);
        send(0, 0, 1);
        send(5, 0, 0);
        drain("frame_err");

        send(4, 1, 0);
        idle(3);
        send(8, 0, 0);
        idle(3);
        send(12, 0, 0);
        idle(3);
        send(16, 0, 1);
        drain("gaps");

        send(100, 1, 0);
        send(100, 0, 0);
        rst_n = 1'b0;
        q.delete();
        eq.delete();
        win.delete();
        m_in = 1'b0;
        @(negedge clk);
        chk_reset("mid_reset");
        rst_n = 1'b1;
        idle(4);
        for (int i = 0; i < 4; i++) send(4, i == 0, i == 3);
        drain("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
